// File: rtl/i4004_cycle_seq.sv
// i4004 instruction-cycle sequencer: 8-phase machine cycle, PC nibble output,
// OPR/OPA fetch, double-word tracking and a circular return-address stack.
module i4004_cycle_seq #(
    parameter int CLK_PER_PHASE = 2,
    parameter int STACK_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  dbus_in,
    output logic [3:0]  dbus_out,
    output logic [2:0]  phase,
    output logic        clken_1,
    output logic        clken_2,
    output logic        sync,
    output logic        cm_rom,
    output logic [11:0] pc,
    output logic        instr_done,
    output logic [15:0] instr_word,
    output logic        is_word2,
    input  logic        ctl_jump,
    input  logic        ctl_call,
    input  logic        ctl_ret,
    input  logic [11:0] ctl_addr,
    output logic        stack_ovf,
    output logic        stack_unf
);

    localparam int SLOTS = STACK_DEPTH - 1;
    localparam int SW    = (CLK_PER_PHASE > 1) ? $clog2(CLK_PER_PHASE) : 1;
    localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW    = $clog2(SLOTS + 1);

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

    phase_t          cur;
    logic [SW-1:0]   sub;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic [11:0]     slot [SLOTS];
    logic            dbl;
    logic [3:0]      opr1, opa1, opr2, opa2;
    logic            last;
    logic [PW-1:0]   ptr_next, ptr_prev;

    function automatic logic is_double(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
               ((opr == 4'h2) && !opa[0]);
    endfunction

    assign last       = (sub == SW'(CLK_PER_PHASE - 1));
    assign phase      = cur;
    assign clken_1    = (sub == '0);
    assign clken_2    = last;
    assign sync       = (cur == X3);
    assign cm_rom     = (cur == A3);
    // A cycle completes at the end of X3 unless it was the first word of a pair
    assign instr_done = (cur == X3) && last && (is_word2 || !dbl);
    assign instr_word = {opr1, opa1, opr2, opa2};
    assign ptr_next   = (ptr == PW'(SLOTS - 1)) ? '0 : ptr + 1'b1;
    assign ptr_prev   = (ptr == '0) ? PW'(SLOTS - 1) : ptr - 1'b1;

    always_comb begin
        dbus_out = 4'h0;
        case (cur)
            A1:      dbus_out = pc[3:0];
            A2:      dbus_out = pc[7:4];
            A3:      dbus_out = pc[11:8];
            default: dbus_out = 4'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur       <= A1;
            sub       <= '0;
            pc        <= '0;
            ptr       <= '0;
            count     <= '0;
            is_word2  <= 1'b0;
            dbl       <= 1'b0;
            opr1      <= '0;
            opa1      <= '0;
            opr2      <= '0;
            opa2      <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
        end else begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            if (last) begin
                sub <= '0;
                cur <= phase_t'(cur + 3'd1);
            end else begin
                sub <= sub + 1'b1;
            end

            if (last) begin
                case (cur)
                    M1: begin
                        if (is_word2) begin
                            opr2 <= dbus_in;
                        end else begin
                            opr1 <= dbus_in;
                            opr2 <= '0;
                            opa2 <= '0;
                        end
                    end
                    M2: begin
                        if (is_word2) begin
                            opa2 <= dbus_in;
                        end else begin
                            opa1 <= dbus_in;
                            dbl  <= is_double(opr1, dbus_in);
                        end
                        pc <= pc + 12'd1;
                    end
                    X3: begin
                        if (is_word2)
                            is_word2 <= 1'b0;
                        else if (dbl)
                            is_word2 <= 1'b1;
                        // Flow control only lands on a completed instruction
                        if (instr_done) begin
                            if (ctl_ret) begin
                                if (count != '0) begin
                                    ptr   <= ptr_prev;
                                    count <= count - 1'b1;
                                    pc    <= slot[ptr_prev];
                                end else begin
                                    stack_unf <= 1'b1;
                                end
                            end else if (ctl_call) begin
                                slot[ptr] <= pc;
                                ptr       <= ptr_next;
                                pc        <= ctl_addr;
                                if (count == CW'(SLOTS))
                                    stack_ovf <= 1'b1;
                                else
                                    count <= count + 1'b1;
                            end else if (ctl_jump) begin
                                pc <= ctl_addr;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i4004_cycle_seq.sv
// Directed self-checking bench for i4004_cycle_seq: phase timing, fetch,
// double-word handling, PC wrap, return stack and mid-cycle reset.
module tb_i4004_cycle_seq;

    logic        clk;
    logic        rst;
    logic [3:0]  dbus_in;
    logic [3:0]  dbus_out;
    logic [2:0]  phase;
    logic        clken_1, clken_2, sync, cm_rom;
    logic [11:0] pc;
    logic        instr_done;
    logic [15:0] instr_word;
    logic        is_word2;
    logic        ctl_jump, ctl_call, ctl_ret;
    logic [11:0] ctl_addr;
    logic        stack_ovf, stack_unf;

    int checks   = 0;
    int failures = 0;

    logic [11:0] a_pc;
    logic        done;
    logic [15:0] word;
    logic        w2_start;

    i4004_cycle_seq #(.CLK_PER_PHASE(2), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .dbus_in(dbus_in), .dbus_out(dbus_out),
        .phase(phase), .clken_1(clken_1), .clken_2(clken_2), .sync(sync),
        .cm_rom(cm_rom), .pc(pc), .instr_done(instr_done),
        .instr_word(instr_word), .is_word2(is_word2), .ctl_jump(ctl_jump),
        .ctl_call(ctl_call), .ctl_ret(ctl_ret), .ctl_addr(ctl_addr),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one 16-clk machine cycle from A1/sub 0, feeding opr in M1 and opa in M2
    task automatic run_cycle(input logic [3:0] opr, input logic [3:0] opa,
                             output logic [11:0] pc_a, output logic done_o,
                             output logic [15:0] word_o, output logic w2_o);
        pc_a   = '0;
        done_o = 1'b0;
        word_o = '0;
        w2_o   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            dbus_in = (k / 2 == 3) ? opr : (k / 2 == 4) ? opa : 4'h0;
            if (k == 0) begin
                pc_a[3:0] = dbus_out;
                w2_o      = is_word2;
            end
            if (k == 2) pc_a[7:4]  = dbus_out;
            if (k == 4) pc_a[11:8] = dbus_out;
            if (k == 15) begin
                done_o = instr_done;
                word_o = instr_word;
            end
            tick();
        end
        dbus_in = 4'h0;
    endtask

    task automatic set_ctl(input logic r, input logic c, input logic j, input logic [11:0] a);
        ctl_ret  = r;
        ctl_call = c;
        ctl_jump = j;
        ctl_addr = a;
    endtask

    initial begin
        rst = 1'b0;
        dbus_in = 4'h0;
        set_ctl(0, 0, 0, 12'h000);
        repeat (2) tick();

        check_output("rst_phase", 32'(phase), 32'h0);
        check_output("rst_pc", 32'(pc), 32'h0);
        check_output("rst_dbus_out", 32'(dbus_out), 32'h0);
        check_output("rst_clken_1", 32'(clken_1), 32'h1);
        check_output("rst_clken_2", 32'(clken_2), 32'h0);
        check_output("rst_sync", 32'(sync), 32'h0);
        check_output("rst_cm_rom", 32'(cm_rom), 32'h0);
        check_output("rst_instr_done", 32'(instr_done), 32'h0);
        check_output("rst_instr_word", 32'(instr_word), 32'h0);
        check_output("rst_is_word2", 32'(is_word2), 32'h0);
        check_output("rst_stack_ovf", 32'(stack_ovf), 32'h0);
        check_output("rst_stack_unf", 32'(stack_unf), 32'h0);

        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_output($sformatf("nop_phase_k%0d", k), 32'(phase), 32'(k / 2));
            check_output($sformatf("nop_sync_k%0d", k), 32'(sync), 32'(k >= 14));
            check_output($sformatf("nop_cm_rom_k%0d", k), 32'(cm_rom), 32'(k == 4 || k == 5));
            check_output($sformatf("nop_clken_1_k%0d", k), 32'(clken_1), 32'(k % 2 == 0));
            check_output($sformatf("nop_clken_2_k%0d", k), 32'(clken_2), 32'(k % 2 == 1));
            check_output($sformatf("nop_done_k%0d", k), 32'(instr_done), 32'(k == 15));
            check_output($sformatf("nop_dbus_out_k%0d", k), 32'(dbus_out), 32'h0);
            tick();
        end
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("nop2_a_pc", 32'(a_pc), 32'h001);
        check_output("nop2_done", 32'(done), 32'h1);
        check_output("nop2_word", 32'(word), 32'h0000);

        // JUN word 1; a jump request here must be ignored since no instr_done occurs
        set_ctl(0, 0, 1, 12'h555);
        run_cycle(4'h4, 4'h1, a_pc, done, word, w2_start);
        check_output("jun1_a_pc", 32'(a_pc), 32'h002);
        check_output("jun1_done", 32'(done), 32'h0);
        check_output("jun1_is_word2", 32'(is_word2), 32'h1);
        check_output("jun1_pc_ignored_jump", 32'(pc), 32'h003);
        set_ctl(0, 0, 1, 12'h123);
        run_cycle(4'h2, 4'h3, a_pc, done, word, w2_start);
        check_output("jun2_w2_start", 32'(w2_start), 32'h1);
        check_output("jun2_a_pc", 32'(a_pc), 32'h003);
        check_output("jun2_done", 32'(done), 32'h1);
        check_output("jun2_word", 32'(word), 32'h4123);
        check_output("jun2_is_word2", 32'(is_word2), 32'h0);
        check_output("jun2_pc", 32'(pc), 32'h123);
        set_ctl(0, 0, 0, 12'h000);
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("after_jun_a_pc", 32'(a_pc), 32'h123);

        set_ctl(0, 0, 1, 12'hFFF);
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("jump_fff_pc", 32'(pc), 32'hFFF);
        set_ctl(0, 0, 0, 12'h000);
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("wrap_a_pc", 32'(a_pc), 32'hFFF);
        check_output("wrap_pc", 32'(pc), 32'h000);

        set_ctl(0, 0, 1, 12'h010);
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("jump_010_pc", 32'(pc), 32'h010);
        for (int i = 1; i <= 4; i++) begin
            set_ctl(0, 1, 0, 12'(16 * (i + 1)));
            run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
            check_output($sformatf("call%0d_pc", i), 32'(pc), 32'(16 * (i + 1)));
            check_output($sformatf("call%0d_ovf", i), 32'(stack_ovf), 32'(i == 4));
        end
        for (int i = 1; i <= 3; i++) begin
            set_ctl(1, 0, 0, 12'h000);
            run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
            check_output($sformatf("ret%0d_pc", i), 32'(pc), 32'(16 * (5 - i) + 1));
            check_output($sformatf("ret%0d_unf", i), 32'(stack_unf), 32'h0);
        end
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("ret4_pc", 32'(pc), 32'h022);
        check_output("ret4_unf", 32'(stack_unf), 32'h1);

        set_ctl(0, 1, 0, 12'h100);
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("prio_call_pc", 32'(pc), 32'h100);
        set_ctl(1, 1, 1, 12'h300);
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("prio_ret_pc", 32'(pc), 32'h023);
        check_output("prio_ret_ovf", 32'(stack_ovf), 32'h0);
        set_ctl(1, 0, 0, 12'h000);
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("prio_empty_pc", 32'(pc), 32'h024);
        check_output("prio_empty_unf", 32'(stack_unf), 32'h1);
        set_ctl(0, 0, 0, 12'h000);

        // FIM word 1 aborted by reset during M2
        for (int k = 0; k < 9; k++) begin
            dbus_in = (k / 2 == 3) ? 4'h2 : (k / 2 == 4) ? 4'h0 : 4'h0;
            tick();
        end
        check_output("fim_pre_phase", 32'(phase), 32'h4);
        rst = 1'b0;
        #1;
        check_output("fim_rst_phase", 32'(phase), 32'h0);
        check_output("fim_rst_pc", 32'(pc), 32'h000);
        check_output("fim_rst_is_word2", 32'(is_word2), 32'h0);
        check_output("fim_rst_instr_word", 32'(instr_word), 32'h0);
        check_output("fim_rst_clken_1", 32'(clken_1), 32'h1);
        tick();
        rst = 1'b1;
        run_cycle(4'h0, 4'h0, a_pc, done, word, w2_start);
        check_output("post_rst_w2_start", 32'(w2_start), 32'h0);
        check_output("post_rst_a_pc", 32'(a_pc), 32'h000);
        check_output("post_rst_done", 32'(done), 32'h1);
        check_output("post_rst_word", 32'(word), 32'h0000);
        check_output("post_rst_pc", 32'(pc), 32'h001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i4004_cycle_seq.md
Name: i4004_cycle_seq

Overview:
- Instruction-cycle sequencer and program-address controller for the i4004 core.
- Generates the 8-phase machine cycle (A1,A2,A3,M1,M2,X1,X2,X3), clock enables and sync.
- Drives the program counter out as nibbles during A1–A3 and fetches OPR/OPA during M1/M2.
- Tracks single- vs double-word instructions and executes jump/call/return requests against an internal circular return-address stack. Execute-unit decode sits downstream of this block.

Parameters:
- CLK_PER_PHASE, 2, clk cycles per machine phase (≥2).
- STACK_DEPTH, 4, address-register levels including PC; saved return slots = STACK_DEPTH-1.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- dbus_in  in  4  ROM data nibble, sampled in M1/M2
- dbus_out  out  4  PC nibble during A1/A2/A3, else 0
- phase  out  3  current phase, A1=0 … X3=7
- clken_1  out  1  high on sub-count 0 of every phase
- clken_2  out  1  high on sub-count CLK_PER_PHASE-1 of every phase
- sync  out  1  high for all of X3
- cm_rom  out  1  high for all of A3
- pc  out  12  current program address
- instr_done  out  1  one-clock pulse, last clk of X3 of a completed instruction
- instr_word  out  16  {opr1,opa1,opr2,opa2}; opr2/opa2 = 0 for single-word; valid while instr_done is high
- is_word2  out  1  current cycle fetches the second word
- ctl_jump  in  1  load pc from ctl_addr
- ctl_call  in  1  push return address, load pc from ctl_addr
- ctl_ret  in  1  pop return address into pc
- ctl_addr  in  12  jump/call target
- stack_ovf  out  1  one-clock pulse, push while full
- stack_unf  out  1  one-clock pulse, pop while empty

Behaviour:
- Async reset (rst=0):
  - sub-count=0, phase=A1, pc=0, stack pointer=0, count=0, is_word2=0, latched words=0.
  - All outputs 0, except clken_1, which is combinational from sub-count and therefore reads 1.
- Sub-counter 0..CLK_PER_PHASE-1 wraps; phase advances on wrap, X3→A1.
- dbus_out:
  - A1 = pc[3:0], A2 = pc[7:4], A3 = pc[11:8]. Combinational from phase/pc.
  - 0 in M1–X3.
- Fetch:
  - On the last clk of M1, dbus_in is latched as OPR (word1 or word2 per is_word2).
  - On the last clk of M2, dbus_in is latched as OPA, and pc <= pc+1 mod 4096 (0xFFF→0x000).
- Double-word decode, at the last clk of M2 with is_word2=0:
  - Double-word when OPR ∈ {1 JCN, 4 JUN, 5 JMS, 7 ISZ}, or OPR=2 with OPA[0]=0 (FIM).
  - Double-word: set is_word2 at end of X3; no instr_done in this cycle.
  - Single-word: instr_done pulses at the last clk of X3.
- Second-word cycle: instr_done pulses at the last clk of X3; is_word2 clears at the same edge.
- ctl_* sampling:
  - Sampled only on the clk where instr_done=1; ignored otherwise.
  - Priority ret > call > jump when more than one is asserted.
  - Effect lands at the same edge, so A1 of the next cycle emits the new pc.
- Call:
  - Writes the already-incremented pc into slot[ptr]; ptr = (ptr+1) mod (STACK_DEPTH-1); count = min(count+1, STACK_DEPTH-1).
  - If count was full, the oldest entry is overwritten and stack_ovf pulses.
- Ret:
  - If count>0: ptr--, count--, pc <= slot[ptr-1].
  - If count==0: pc keeps its incremented value, ptr/count unchanged, stack_unf pulses.
- Jump: pc <= ctl_addr; stack untouched.
- Reset asserted mid-cycle aborts immediately, including any half-fetched double-word. After release, the first cycle starts at A1 with pc=0.

Test Plan:
- Reset release, dbus_in=0x0 (NOP) → phase sequence 0..7 with 2 clks each; sync high clks 14–15; cm_rom high clks 4–5; dbus_out 0,0,0 then pc=1 next A phases; instr_done every 16 clks.
- ROM feeds 0x4,0x1 then 0x2,0x3 (JUN 0x123) → first cycle no instr_done, is_word2=1; second cycle instr_done with instr_word=0x4123; drive ctl_jump, ctl_addr=0x123 → next A1..A3 dbus_out=3,2,1.
- pc forced to 0xFFF via jump, fetch NOP → pc wraps to 0x000.
- Four ctl_call at pc 0x010,0x020,0x030,0x040 → stack_ovf on the 4th only; three ctl_ret restore 0x041,0x031,0x021; 4th ret → stack_unf, pc keeps its increment.
- ctl_ret+ctl_call+ctl_jump together at instr_done → only ret applied; ctl_jump asserted outside instr_done → ignored.
- rst pulsed low during M2 of word1 of FIM (0x2,0x0) → all outputs cleared asynchronously; after release, fetch restarts at pc=0 with is_word2=0.
